plugboard_ctrl: RTL

PLUGBOARD_CTRL -- requirements
Module: plugboard_ctrl

---
 rtl/plugboard_pkg.sv | 49 ++++
 rtl/plugboard_map.sv | 52 +++++
 rtl/plugboard_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/plugboard_pkg.sv
// plugboard_pkg -- shared definitions for the plugboard controller.
//   LETTERS       : alphabet size (26)
//   letter_t      : 5-bit letter index, 0=A .. 25=Z
//   state_t       : controller FSM states
//   onehot_to_idx : one-hot letter vector -> index
//   idx_to_onehot : index -> one-hot letter vector (zero when out of range)
//   is_onehot     : true when exactly one bit is set
package plugboard_pkg;

  localparam int LETTERS = 26;

  typedef logic [4:0] letter_t;

  localparam letter_t LETTER_LIMIT = letter_t'(LETTERS);

  typedef enum logic [1:0] {
    CFG_FIRST  = 2'd0,
    CFG_SECOND = 2'd1,
    RUN        = 2'd2
  } state_t;

  // For a non-one-hot vector the result is meaningless; callers
  // qualify it with is_onehot.
  function automatic letter_t onehot_to_idx(input logic [LETTERS-1:0] v);
    letter_t idx;
    idx = '0;
    for (int i = 0; i < LETTERS; i++) begin
      if (v[i]) idx = idx | letter_t'(i);
    end
    return idx;
  endfunction

  function automatic logic [LETTERS-1:0] idx_to_onehot(input letter_t idx);
    logic [LETTERS-1:0] v;
    v = '0;
    if (idx < LETTER_LIMIT) v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic is_onehot(input logic [LETTERS-1:0] v);
    int ones;
    ones = 0;
    for (int i = 0; i < LETTERS; i++) begin
      if (v[i]) ones++;
    end
    return (ones == 1);
  endfunction

endpackage

// File: rtl/plugboard_map.sv
// plugboard_map -- 26-entry letter swap table.
//   CLOCK_50    : clock
//   reset       : synchronous active-low reset, table back to identity
//   clear       : return table to identity
//   wr_en       : store pair wr_a <-> wr_b
//   erase_en    : remove the pair containing erase_idx
//   key_idx     : read port used while configuring -> key_partner
//   run_idx     : read port used while translating  -> run_partner
// Reads of an out-of-range index return the index itself, so a letter
// that is not plugged (or not a letter at all) looks like its own partner.
module plugboard_map
  import plugboard_pkg::*;
(
  input  logic    CLOCK_50,
  input  logic    reset,
  input  logic    clear,
  input  logic    wr_en,
  input  letter_t wr_a,
  input  letter_t wr_b,
  input  logic    erase_en,
  input  letter_t erase_idx,
  input  letter_t key_idx,
  output letter_t key_partner,
  input  letter_t run_idx,
  output letter_t run_partner
);

  letter_t swap_q [LETTERS];
  letter_t erase_partner;

  // Combinational lookups, guarded against indices past Z.
  always_comb begin
    key_partner   = (key_idx < LETTER_LIMIT) ? swap_q[key_idx] : key_idx;
    run_partner   = (run_idx < LETTER_LIMIT) ? swap_q[run_idx] : run_idx;
    erase_partner = (erase_idx < LETTER_LIMIT) ? swap_q[erase_idx] : erase_idx;
  end

  // Table update: identity on reset/clear, otherwise a symmetric pair
  // write or a symmetric pair erase. The controller never requests both.
  always_ff @(posedge CLOCK_50) begin
    if (!reset || clear) begin
      for (int i = 0; i < LETTERS; i++) swap_q[i] <= letter_t'(i);
    end else if (wr_en) begin
      swap_q[wr_a] <= wr_b;
      swap_q[wr_b] <= wr_a;
    end else if (erase_en) begin
      swap_q[erase_idx]     <= erase_idx;
      swap_q[erase_partner] <= erase_partner;
    end
  end

endmodule

// File: rtl/plugboard_ctrl.sv
// plugboard_ctrl -- Enigma-style plugboard: pair configuration, then
// one-letter-per-cycle translation.
//   CLOCK_50   : clock
//   reset      : synchronous active-low reset
//   key_valid  : strobe qualifying key_code while configuring
//   key_code   : letter index 0=A..25=Z
//   cfg_clear  : clear all pairs, back to configuration (highest priority)
//   lock       : enter RUN from configuration
//   in_valid   : qualifies in during RUN
//   in         : one-hot letter to translate
//   out        : one-hot translated letter (latency 1)
//   out_valid  : out qualifier, one cycle
//   pair_count : committed pairs
//   running    : high in RUN
//   err        : one-cycle pulse for rejected key or non-one-hot input
// Build option: PLUGBOARD_UNPLUG_EN -- a first key naming a plugged
// letter removes that pair instead of being rejected.
module plugboard_ctrl
  import plugboard_pkg::*;
#(
  parameter int MAX_PAIRS = 10
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               key_valid,
  input  logic [4:0]         key_code,
  input  logic               cfg_clear,
  input  logic               lock,
  input  logic               in_valid,
  input  logic [LETTERS-1:0] in,
  output logic [LETTERS-1:0] out,
  output logic               out_valid,
  output logic [3:0]         pair_count,
  output logic               running,
  output logic               err
);

  localparam logic [3:0] MAX_COUNT = 4'(MAX_PAIRS);

  state_t             state_q, state_d;
  letter_t            pending_q, pending_d;
  logic [3:0]         count_q, count_d;
  logic [LETTERS-1:0] out_d;
  logic               out_valid_d, err_d;

  logic    map_clear, map_wr, map_erase;
  letter_t key_partner, run_partner;
  logic    key_ok, key_plugged;

  plugboard_map u_map (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .clear       (map_clear),
    .wr_en       (map_wr),
    .wr_a        (pending_q),
    .wr_b        (key_code),
    .erase_en    (map_erase),
    .erase_idx   (key_code),
    .key_idx     (key_code),
    .key_partner (key_partner),
    .run_idx     (onehot_to_idx(in)),
    .run_partner (run_partner)
  );

  // Next-state and registered-output logic. cfg_clear overrides
  // everything; lock beats a simultaneous key, which is dropped silently.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    count_d     = count_q;
    out_d       = '0;
    out_valid_d = 1'b0;
    err_d       = 1'b0;
    map_clear   = 1'b0;
    map_wr      = 1'b0;
    map_erase   = 1'b0;

    key_ok      = (key_code < LETTER_LIMIT);
    key_plugged = key_ok && (key_partner != key_code);

    if (cfg_clear) begin
      map_clear = 1'b1;
      count_d   = '0;
      pending_d = '0;
      state_d   = CFG_FIRST;
    end else begin
      case (state_q)
        CFG_FIRST: begin
          if (lock) begin
            state_d = RUN;
          end else if (key_valid) begin
            if (!key_ok) begin
              err_d = 1'b1;
            end else if (key_plugged) begin
`ifdef PLUGBOARD_UNPLUG_EN
              map_erase = 1'b1;
              count_d   = count_q - 4'd1;
`else
              err_d = 1'b1;
`endif
            end else if (count_q == MAX_COUNT) begin
              err_d = 1'b1;
            end else begin
              pending_d = key_code;
              state_d   = CFG_SECOND;
            end
          end
        end

        // The pending letter is not yet in the table, so the "same as
        // pending" case needs its own check.
        CFG_SECOND: begin
          if (lock) begin
            state_d   = RUN;
            pending_d = '0;
          end else if (key_valid) begin
            if (!key_ok || key_plugged || (key_code == pending_q)) begin
              err_d = 1'b1;
            end else begin
              map_wr  = 1'b1;
              count_d = count_q + 4'd1;
              state_d = CFG_FIRST;
            end
          end
        end

        RUN: begin
          if (in_valid) begin
            out_valid_d = 1'b1;
            if (is_onehot(in)) out_d = idx_to_onehot(run_partner);
            else               err_d = 1'b1;
          end
        end

        default: state_d = CFG_FIRST;
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_q   <= CFG_FIRST;
      pending_q <= '0;
      count_q   <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      out       <= out_d;
      out_valid <= out_valid_d;
      err       <= err_d;
    end
  end

  assign pair_count = count_q;
  assign running    = (state_q == RUN);

endmodule
